// File: rtl/block_sync.sv
// 64b/66b sync-header lock FSM that steers gearbox slip and writes aligned blocks to the RX FIFO (1-cycle latency).
// No backpressure: every rx_valid block is consumed. Define BLOCK_SYNC_ERRCNT_EN to add the saturating sh_err_cnt output.
module block_sync #(
  parameter int DSIZE      = 66,
  parameter int SH_CNT_MAX = 64,
  parameter int INVLD_MAX  = 16,
  parameter int SLIP_WAIT  = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [DSIZE-1:0] rx_data,
  input  logic             rx_valid,
  output logic             slip,
  output logic             block_lock,
  output logic [DSIZE-1:0] wdata,
  output logic             winc
`ifdef BLOCK_SYNC_ERRCNT_EN
  ,
  output logic [7:0]       sh_err_cnt
`endif
);

  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(INVLD_MAX + 1);
  localparam logic [CW-1:0] CNT_END   = CW'(SH_CNT_MAX);
  localparam logic [CW-1:0] WAIT_END  = CW'(SLIP_WAIT);
  localparam logic [IW-1:0] INVLD_END = IW'(INVLD_MAX);

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP_HOLD = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] sh_cnt;
  logic [CW-1:0] sh_cnt_nx;
  logic [CW-1:0] sh_cnt_inc;
  logic [IW-1:0] sh_invld_cnt;
  logic [IW-1:0] invld_nx;
  logic [IW-1:0] invld_inc;
  logic          sh_ok;
  logic          slip_nx;
  logic          lock_nx;
  logic          winc_nx;

  assign sh_ok      = rx_data[1] ^ rx_data[0];
  assign sh_cnt_inc = sh_cnt + CW'(1);
  assign invld_inc  = sh_invld_cnt + IW'(1);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state        <= LOCK_INIT;
      sh_cnt       <= '0;
      sh_invld_cnt <= '0;
      slip         <= 1'b0;
      block_lock   <= 1'b0;
      winc         <= 1'b0;
      wdata        <= '0;
    end else begin
      state        <= state_nx;
      sh_cnt       <= sh_cnt_nx;
      sh_invld_cnt <= invld_nx;
      slip         <= slip_nx;
      block_lock   <= lock_nx;
      winc         <= winc_nx;
      if (winc_nx) begin
        wdata <= rx_data;
      end
    end
  end

  // Counters clear at their limit, so they can never wrap.
  always_comb begin
    state_nx  = state;
    sh_cnt_nx = sh_cnt;
    invld_nx  = sh_invld_cnt;
    case (state)
      LOCK_INIT: begin
        state_nx  = TEST_SH;
        sh_cnt_nx = '0;
        invld_nx  = '0;
      end
      TEST_SH: begin
        if (rx_valid) begin
          if (!sh_ok) begin
            state_nx  = SLIP_HOLD;
            sh_cnt_nx = '0;
            invld_nx  = '0;
          end else if (sh_cnt_inc == CNT_END) begin
            state_nx  = LOCKED;
            sh_cnt_nx = '0;
            invld_nx  = '0;
          end else begin
            sh_cnt_nx = sh_cnt_inc;
          end
        end
      end
      SLIP_HOLD: begin
        // sh_cnt doubles as the settle counter; headers are not examined here.
        if (rx_valid) begin
          if (sh_cnt_inc >= WAIT_END) begin
            state_nx  = TEST_SH;
            sh_cnt_nx = '0;
            invld_nx  = '0;
          end else begin
            sh_cnt_nx = sh_cnt_inc;
          end
        end
      end
      LOCKED: begin
        if (rx_valid) begin
          if (!sh_ok && (invld_inc == INVLD_END)) begin
            state_nx  = SLIP_HOLD;
            sh_cnt_nx = '0;
            invld_nx  = '0;
          end else if (sh_cnt_inc == CNT_END) begin
            sh_cnt_nx = '0;
            invld_nx  = '0;
          end else begin
            sh_cnt_nx = sh_cnt_inc;
            if (!sh_ok) begin
              invld_nx = invld_inc;
            end
          end
        end
      end
      default: begin
        state_nx  = LOCK_INIT;
        sh_cnt_nx = '0;
        invld_nx  = '0;
      end
    endcase
  end

  // The block that breaks lock is not written, so winc drops together with block_lock.
  always_comb begin
    lock_nx = (state_nx == LOCKED);
    slip_nx = (state_nx == SLIP_HOLD) && (state != SLIP_HOLD);
    winc_nx = rx_valid && block_lock && lock_nx;
  end

`ifdef BLOCK_SYNC_ERRCNT_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      sh_err_cnt <= 8'd0;
    end else if ((state == LOCKED) && rx_valid && !sh_ok && (sh_err_cnt != 8'hFF)) begin
      sh_err_cnt <= sh_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_sync.sv
// Directed bench for block_sync: the driver queues the expected registered outputs per block, a negedge monitor compares.
module tb_block_sync;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic [65:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        slip;
  logic        block_lock;
  logic [65:0] wdata;
  logic        winc;
`ifdef BLOCK_SYNC_ERRCNT_EN
  logic [7:0]  sh_err_cnt;
`endif

  always #5 wclk = ~wclk;

  block_sync #(
    .DSIZE(66), .SH_CNT_MAX(64), .INVLD_MAX(16), .SLIP_WAIT(2)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .slip      (slip),
    .block_lock(block_lock),
    .wdata     (wdata),
    .winc      (winc)
`ifdef BLOCK_SYNC_ERRCNT_EN
    ,
    .sh_err_cnt(sh_err_cnt)
`endif
  );

  typedef struct {
    string       tag;
    logic        e_slip;
    logic        e_lock;
    logic        e_winc;
    logic [65:0] e_wd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [65:0] last_wd = '0;
  logic [63:0] seq = 64'h0000_1000;
  localparam logic [65:0] DEAD = 66'h2_DEAD_BEEF_0123_4567;

  task automatic chk1(string tag, string what, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got %0b expected %0b at %0t", tag, what, got, exp, $time);
    end
  endtask

  task automatic chkw(string tag, string what, logic [65:0] got, logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got %h expected %h at %0t", tag, what, got, exp, $time);
    end
  endtask

  always @(negedge wclk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk1(e.tag, "slip", slip, e.e_slip);
      chk1(e.tag, "block_lock", block_lock, e.e_lock);
      chk1(e.tag, "winc", winc, e.e_winc);
      chkw(e.tag, "wdata", wdata, e.e_wd);
    end
  end

  // Drive one cycle at a negedge and queue what the outputs must show after the next posedge.
  task automatic cycd(string tag, logic v, logic [65:0] d, logic es, logic el, logic ew);
    exp_t e;
    rx_valid = v;
    rx_data  = d;
    if (ew) last_wd = d;
    e.tag    = tag;
    e.e_slip = es;
    e.e_lock = el;
    e.e_winc = ew;
    e.e_wd   = last_wd;
    @(posedge wclk);
    sb.push_back(e);
    @(negedge wclk);
  endtask

  task automatic cyc(string tag, logic v, logic [1:0] hdr, logic es, logic el, logic ew);
    logic [65:0] d;
    d   = {seq, hdr};
    seq = seq + 64'd1;
    cycd(tag, v, d, es, el, ew);
  endtask

  task automatic lock_up(string tag);
    for (int i = 0; i < 64; i++) begin
      cyc(tag, 1'b1, (i % 2 == 1) ? 2'b10 : 2'b01, 1'b0, (i == 63), 1'b0);
    end
  endtask

  task automatic do_reset(string tag);
    #2 wrst_n = 1'b0;
    #1;
    chk1(tag, "slip", slip, 1'b0);
    chk1(tag, "block_lock", block_lock, 1'b0);
    chk1(tag, "winc", winc, 1'b0);
    chkw(tag, "wdata", wdata, 66'd0);
`ifdef BLOCK_SYNC_ERRCNT_EN
    chkw(tag, "sh_err_cnt", {58'd0, sh_err_cnt}, 66'd0);
`endif
    rx_valid = 1'b0;
    last_wd  = '0;
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    cyc("init", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("init", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk1("reset", "slip", slip, 1'b0);
    chk1("reset", "block_lock", block_lock, 1'b0);
    chk1("reset", "winc", winc, 1'b0);
    chkw("reset", "wdata", wdata, 66'd0);
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    cyc("init", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("init", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);

    // First lock: 64 good headers, block_lock on the 64th, no slip.
    lock_up("lock64");

    // Locked pass-through with rx_valid toggling (DEAD carries header 11: 4 invalid).
    for (int k = 0; k < 4; k++) begin
      cycd("toggle", 1'b1, DEAD, 1'b0, 1'b1, 1'b1);
      cycd("toggle", 1'b0, DEAD, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 60; i++) cyc("fill", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);

    // Two windows with 15 invalid each: lock holds only if counts restart per window.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 64; i++) begin
        cyc("win15", 1'b1,
            (i % 4 == 0 && i < 60) ? ((i % 8 == 0) ? 2'b00 : 2'b11) : 2'b01,
            1'b0, 1'b1, 1'b1);
      end
    end

    // Sixteenth invalid in one window breaks lock with a slip and no write.
    for (int i = 0; i < 31; i++) begin
      cyc("win16", 1'b1, (i % 2 == 0) ? 2'b11 : 2'b01, (i == 30), (i != 30), (i != 30));
    end
    cyc("hold", 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc("hold", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc("hold", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);

    // Unlocked slip: 10 good, one bad, two ignored, then relock.
    cyc("idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc("pre_slip", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("slip", 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    cyc("ignored", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("ignored", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i == 20) cyc("gap", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      cyc("relock", 1'b1, 2'b10, 1'b0, (i == 63), 1'b0);
    end

    // Reset mid-window while locked, then mid-acquisition: acquisition must restart from zero.
    for (int i = 0; i < 10; i++) cyc("pre_rst", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
    do_reset("rst_locked");
    for (int i = 0; i < 40; i++) cyc("partial", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    do_reset("rst_test");
    lock_up("after_rst");

`ifdef BLOCK_SYNC_ERRCNT_EN
    for (int r = 1; r <= 19; r++) begin
      for (int i = 0; i < 16; i++) cyc("err", 1'b1, 2'b00, (i == 15), (i != 15), (i != 15));
      cyc("err_hold", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      cyc("err_hold", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      lock_up("err_relock");
      chkw("sh_err_cnt", "count", {58'd0, sh_err_cnt}, (r * 16 > 255) ? 66'd255 : 66'(r * 16));
    end
    for (int i = 0; i < 5; i++) cyc("err_mid", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
    do_reset("rst_errcnt");
`endif

    repeat (2) @(negedge wclk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard left %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
